// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and the issue-slot state type.
// Compile with ALU_ISSUE_FWD_EN defined to enable last-result forwarding in alu_issue.
package alu_issue_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int OP_W       = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_SLL  = 5'd2,
        OP_SLT  = 5'd3,
        OP_SLTU = 5'd4,
        OP_XOR  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_OR   = 5'd8,
        OP_AND  = 5'd9,
        OP_EQ   = 5'd10
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-write vector, one bit per architectural register; x0 never pending.
// A set and a clear of the same register in one cycle leave the bit set.
module alu_scoreboard
    import alu_issue_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    input  logic [REG_AW-1:0] rs1_idx_i,
    input  logic [REG_AW-1:0] rs2_idx_i,
    input  logic [REG_AW-1:0] rd_idx_i,
    output logic              rs1_pend_o,
    output logic              rs2_pend_o,
    output logic              rd_pend_o
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_reg
                assign pend_d[gi] = (set_en_i && (set_idx_i == REG_AW'(gi))) ? 1'b1 :
                                    (clr_en_i && (clr_idx_i == REG_AW'(gi))) ? 1'b0 :
                                    pend_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rs1_pend_o = pend_q[rs1_idx_i];
    assign rs2_pend_o = pend_q[rs2_idx_i];
    assign rd_pend_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage ahead of the ALU: operand bypass, RAW/WAW hazard stall, one output slot.
// ALU_ISSUE_FWD_EN adds a one-deep last-result forwarding register.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [XLEN-1:0]   alu_lhs,
    output logic [XLEN-1:0]   alu_rhs,
    output logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_res
);
    slot_state_e       state_q;
    logic [OP_W-1:0]   op_q;
    logic [XLEN-1:0]   lhs_q;
    logic [XLEN-1:0]   rhs_q;
    logic [REG_AW-1:0] rd_q;

    logic accept;
    logic fire;
    logic hazard;
    logic waw;
    logic rs1_pend;
    logic rs2_pend;
    logic rd_pend;
    logic [XLEN-1:0] last_res;

    logic [REG_AW-1:0] src_idx  [2];
    logic [XLEN-1:0]   src_rf   [2];
    logic              src_need [2];
    logic              src_pend [2];
    logic [XLEN-1:0]   src_val  [2];
    logic              src_raw  [2];

    assign alu_valid = (state_q == SLOT_FULL);
    assign alu_op    = op_q;
    assign alu_lhs   = lhs_q;
    assign alu_rhs   = rhs_q;
    assign alu_rd    = rd_q;

    assign fire   = alu_valid && alu_ready;
    assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic              last_v_q;
    logic [REG_AW-1:0] last_rd_q;
    logic [XLEN-1:0]   last_res_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            last_v_q   <= 1'b0;
            last_rd_q  <= '0;
            last_res_q <= '0;
        end else if (fire && (rd_q != '0)) begin
            last_v_q   <= 1'b1;
            last_rd_q  <= rd_q;
            last_res_q <= alu_res;
        end
    end

    assign last_res = last_res_q;
`else
    logic unused_alu_res;
    assign unused_alu_res = ^alu_res;
    assign last_res       = '0;
`endif

    assign src_idx[0]  = in_rs1;
    assign src_idx[1]  = in_rs2;
    assign src_rf[0]   = rf_rs1_data;
    assign src_rf[1]   = rf_rs2_data;
    assign src_need[0] = !in_use_pc;
    assign src_need[1] = !in_use_imm;
    assign src_pend[0] = rs1_pend;
    assign src_pend[1] = rs2_pend;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic wb_hit;
            logic last_hit;
            logic slot_blk;

            assign wb_hit = wb_valid && (wb_rd == src_idx[gi]);
`ifdef ALU_ISSUE_FWD_EN
            assign last_hit = last_v_q && (last_rd_q == src_idx[gi]);
            // The slot's writer has not produced last_res yet, so the copy is stale.
            assign slot_blk = alu_valid && (rd_q == src_idx[gi]);
`else
            assign last_hit = 1'b0;
            assign slot_blk = 1'b0;
`endif
            assign src_val[gi] = (src_idx[gi] == '0) ? '0 :
                                 last_hit            ? last_res :
                                 wb_hit              ? wb_data :
                                 src_rf[gi];

            assign src_raw[gi] = src_need[gi] && src_pend[gi] && !wb_hit &&
                                 !(last_hit && !slot_blk);
        end
    endgenerate

    // A writeback retiring the old writer this cycle lets a new writer in.
    assign waw    = (in_rd != '0) && rd_pend && !(wb_valid && (wb_rd == in_rd));
    assign hazard = src_raw[0] || src_raw[1] || waw;

    assign in_ready = (!alu_valid || alu_ready) && !hazard;

    alu_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk_i      (CLK),
        .rst_ni     (RST_X),
        .set_en_i   (accept && (in_rd != '0)),
        .set_idx_i  (in_rd),
        .clr_en_i   (wb_valid),
        .clr_idx_i  (wb_rd),
        .rs1_idx_i  (in_rs1),
        .rs2_idx_i  (in_rs2),
        .rd_idx_i   (in_rd),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .rd_pend_o  (rd_pend)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= SLOT_EMPTY;
            op_q    <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        state_q <= SLOT_FULL;
                        op_q    <= in_op;
                        lhs_q   <= in_use_pc  ? in_pc  : src_val[0];
                        rhs_q   <= in_use_imm ? in_imm : src_val[1];
                        rd_q    <= in_rd;
                    end
                end
                SLOT_FULL: begin
                    if (accept) begin
                        op_q  <= in_op;
                        lhs_q <= in_use_pc  ? in_pc  : src_val[0];
                        rhs_q <= in_use_imm ? in_imm : src_val[1];
                        rd_q  <= in_rd;
                    end else if (fire) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

endmodule
